// File: rtl/cast_pkg.sv
// ============================================================================
// Module  : cast_pkg
// Shared types and constants for the multicast switch allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cast_pkg;

    localparam int NPORT = 5;

    typedef logic [NPORT-1:0] port_mask_t;
    typedef logic [2:0]       rr_idx_t;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_EAST  = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_NORTH = 3'd4
    } port_idx_e;

    // Modulo-NPORT increment of a round-robin index.
    function automatic rr_idx_t rr_inc(input rr_idx_t idx);
        rr_idx_t nxt;
        if (idx >= rr_idx_t'(NPORT - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cast_mask_rr_arbiter.sv
// ============================================================================
// Module  : cast_mask_rr_arbiter
// Combinational round-robin scan granting requests whose output masks are
// disjoint from busy outputs and from masks granted earlier in the same pass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cast_mask_rr_arbiter
    import cast_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  port_mask_t       i_route [NPORT],
    input  port_mask_t       i_busy,
    input  rr_idx_t          i_ptr,
    output logic [NPORT-1:0] o_gnt,
    output port_mask_t       o_gnt_mask [NPORT],
    output rr_idx_t          o_ptr_next
);

    port_mask_t w_claimed;
    rr_idx_t    w_idx;

    always_comb begin
        o_gnt      = '0;
        o_ptr_next = i_ptr;
        w_claimed  = i_busy;
        w_idx      = i_ptr;
        for (int i = 0; i < NPORT; i++) begin
            o_gnt_mask[i] = '0;
        end
        // Visit inputs in order ptr, ptr+1, ... so the last grant in scan
        // order naturally determines the next pointer.
        for (int k = 0; k < NPORT; k++) begin
            if (i_req[w_idx] && ((i_route[w_idx] & w_claimed) == '0)) begin
                o_gnt[w_idx]      = 1'b1;
                o_gnt_mask[w_idx] = i_route[w_idx];
                w_claimed         = w_claimed | i_route[w_idx];
                o_ptr_next        = rr_inc(w_idx);
            end
            w_idx = rr_inc(w_idx);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cast_allocator.sv
// ============================================================================
// Module  : cast_allocator
// Multicast all-or-nothing switch allocator producing crossbar select masks.
// Optional feature macro: CAST_ALLOC_BYPASS_EN (same-cycle grant bypass).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cast_allocator
    import cast_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NPORT-1:0] valid_in,
    input  logic [NPORT-1:0] head_in,
    input  logic [NPORT-1:0] tail_in,
    input  logic [NPORT-1:0] route_vc0,
    input  logic [NPORT-1:0] route_vc1,
    input  logic [NPORT-1:0] route_vc2,
    input  logic [NPORT-1:0] route_vc3,
    input  logic [NPORT-1:0] route_vc4,
    input  logic [NPORT-1:0] ready_in,
    output logic [NPORT-1:0] selVCfromVC0,
    output logic [NPORT-1:0] selVCfromVC1,
    output logic [NPORT-1:0] selVCfromVC2,
    output logic [NPORT-1:0] selVCfromVC3,
    output logic [NPORT-1:0] selVCfromVC4,
    output logic [NPORT-1:0] busy_out
);

    port_mask_t       w_route    [NPORT];
    port_mask_t       w_sel      [NPORT];
    port_mask_t       w_gnt_mask [NPORT];
    port_mask_t       own_q      [NPORT];
    port_mask_t       own_d      [NPORT];
    port_mask_t       w_busy;
    logic [NPORT-1:0] w_req;
    logic [NPORT-1:0] w_gnt;
    logic [NPORT-1:0] w_xfer;
    rr_idx_t          p_q;
    rr_idx_t          p_d;
    rr_idx_t          w_p_next;

    assign w_route[0] = route_vc0;
    assign w_route[1] = route_vc1;
    assign w_route[2] = route_vc2;
    assign w_route[3] = route_vc3;
    assign w_route[4] = route_vc4;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_busy = w_busy | own_q[i];
        end
    end

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign w_req[gi] = valid_in[gi] & head_in[gi]
                             & (own_q[gi] == '0) & (w_route[gi] != '0);
`ifdef CAST_ALLOC_BYPASS_EN
            // Grant term gated by rstn so reset clears sel without an edge.
            assign w_sel[gi] = own_q[gi] | (w_gnt_mask[gi] & {NPORT{rstn}});
`else
            assign w_sel[gi] = own_q[gi];
`endif
            // Readiness is the AND of ready_in over every selected output.
            assign w_xfer[gi] = valid_in[gi] & (w_sel[gi] != '0)
                              & ((w_sel[gi] & ready_in) == w_sel[gi]);
        end
    endgenerate

    cast_mask_rr_arbiter u_arb (
        .i_req      (w_req),
        .i_route    (w_route),
        .i_busy     (w_busy),
        .i_ptr      (p_q),
        .o_gnt      (w_gnt),
        .o_gnt_mask (w_gnt_mask),
        .o_ptr_next (w_p_next)
    );

    // Release wins over grant: a bypassed single-flit packet that transfers
    // in its grant cycle must not leave its outputs owned.
    always_comb begin
        p_d = w_p_next;
        for (int i = 0; i < NPORT; i++) begin
            own_d[i] = own_q[i];
            if (w_xfer[i] && tail_in[i]) begin
                own_d[i] = '0;
            end else if (w_gnt[i]) begin
                own_d[i] = w_gnt_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q <= rr_idx_t'(RR_INIT);
            for (int i = 0; i < NPORT; i++) begin
                own_q[i] <= '0;
            end
        end else begin
            p_q <= p_d;
            for (int i = 0; i < NPORT; i++) begin
                own_q[i] <= own_d[i];
            end
        end
    end

    assign selVCfromVC0 = w_sel[0];
    assign selVCfromVC1 = w_sel[1];
    assign selVCfromVC2 = w_sel[2];
    assign selVCfromVC3 = w_sel[3];
    assign selVCfromVC4 = w_sel[4];
    assign busy_out     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_cast_allocator.sv
// ============================================================================
// Module  : tb_cast_allocator
// Self-checking bench for cast_allocator: directed vector table, reset and
// round-robin sequences, and randomized traffic against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cast_allocator;

    typedef struct packed {
        logic [4:0]  v;
        logic [4:0]  h;
        logic [4:0]  t;
        logic [24:0] r;
        logic [4:0]  rdy;
        logic [24:0] sel;
        logic [4:0]  busy;
    } vec_t;

    localparam logic [4:0] Z   = 5'b00000;
    localparam logic [4:0] ALL = 5'b11111;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  valid_in = '0;
    logic [4:0]  head_in = '0;
    logic [4:0]  tail_in = '0;
    logic [4:0]  ready_in = '0;
    logic [24:0] route_all = '0;
    logic [4:0]  sel0, sel1, sel2, sel3, sel4;
    logic [4:0]  busy_out;
    logic [24:0] sel_all;

    int passed = 0;
    int total  = 0;

    vec_t tbl[$];

    logic [4:0] m_own [5];
    logic [4:0] m_nxt [5];
    int         m_p;

    assign sel_all = {sel4, sel3, sel2, sel1, sel0};

    always #5 clk = ~clk;

    cast_allocator #(.RR_INIT(0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .valid_in     (valid_in),
        .head_in      (head_in),
        .tail_in      (tail_in),
        .route_vc0    (route_all[4:0]),
        .route_vc1    (route_all[9:5]),
        .route_vc2    (route_all[14:10]),
        .route_vc3    (route_all[19:15]),
        .route_vc4    (route_all[24:20]),
        .ready_in     (ready_in),
        .selVCfromVC0 (sel0),
        .selVCfromVC1 (sel1),
        .selVCfromVC2 (sel2),
        .selVCfromVC3 (sel3),
        .selVCfromVC4 (sel4),
        .busy_out     (busy_out)
    );

    function automatic logic [24:0] m5(input logic [4:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic [4:0] v, h, t, input logic [24:0] r,
                                input logic [4:0] rdy, input logic [24:0] s,
                                input logic [4:0] b);
        vec_t x;
        x.v = v; x.h = h; x.t = t; x.r = r; x.rdy = rdy; x.sel = s; x.busy = b;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] v, h, t, input logic [24:0] r, input logic [4:0] rdy);
        valid_in = v; head_in = h; tail_in = t; route_all = r; ready_in = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(Z, Z, Z, '0, ALL);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Reference model: own masks per input, scan order from pointer p.
    task automatic model_step();
        logic [4:0] busy, claimed, sel, rt;
        int order[$];
        int last;
        busy = '0;
        for (int i = 0; i < 5; i++) busy |= m_own[i];
        claimed = busy;
        last = -1;
        for (int k = 0; k < 5; k++) order.push_back((m_p + k) % 5);
        for (int i = 0; i < 5; i++) begin
            sel = m_own[i];
            m_nxt[i] = m_own[i];
            if (valid_in[i] && sel != 0 && ((sel & ready_in) == sel) && tail_in[i])
                m_nxt[i] = '0;
        end
        foreach (order[k]) begin
            int i;
            i = order[k];
            rt = route_all[i*5 +: 5];
            if (valid_in[i] && head_in[i] && m_own[i] == 0 && rt != 0 && (rt & claimed) == 0) begin
                m_nxt[i] = rt;
                claimed |= rt;
                last = i;
            end
        end
        if (last >= 0) m_p = (last + 1) % 5;
    endtask

    initial begin
        // Directed cycles starting from reset with pointer 0.
        // Unicast 3-flit packet on input 1 to output 2.
        tbl.push_back(mk(5'b00010, 5'b00010, Z, m5(Z,5'b00100,Z,Z,Z), ALL, m5(Z,5'b00100,Z,Z,Z), 5'b00100));
        tbl.push_back(mk(5'b00010, 5'b00010, Z, m5(Z,5'b00100,Z,Z,Z), ALL, m5(Z,5'b00100,Z,Z,Z), 5'b00100));
        tbl.push_back(mk(5'b00010, Z, Z, m5(Z,5'b00100,Z,Z,Z), ALL, m5(Z,5'b00100,Z,Z,Z), 5'b00100));
        tbl.push_back(mk(5'b00010, Z, 5'b00010, m5(Z,5'b00100,Z,Z,Z), ALL, '0, Z));
        tbl.push_back(mk(Z, Z, Z, '0, ALL, '0, Z));
        // Multicast 2-flit packet on input 0; tail stalled two cycles by ready[3].
        tbl.push_back(mk(5'b00001, 5'b00001, Z, m5(5'b01010,Z,Z,Z,Z), ALL, m5(5'b01010,Z,Z,Z,Z), 5'b01010));
        tbl.push_back(mk(5'b00001, 5'b00001, Z, m5(5'b01010,Z,Z,Z,Z), ALL, m5(5'b01010,Z,Z,Z,Z), 5'b01010));
        tbl.push_back(mk(5'b00001, Z, 5'b00001, m5(5'b01010,Z,Z,Z,Z), 5'b10111, m5(5'b01010,Z,Z,Z,Z), 5'b01010));
        tbl.push_back(mk(5'b00001, Z, 5'b00001, m5(5'b01010,Z,Z,Z,Z), 5'b10111, m5(5'b01010,Z,Z,Z,Z), 5'b01010));
        tbl.push_back(mk(5'b00001, Z, 5'b00001, m5(5'b01010,Z,Z,Z,Z), ALL, '0, Z));
        // Disjoint single-flit multicasts on inputs 0 and 3 in the same cycle.
        tbl.push_back(mk(5'b01001, 5'b01001, 5'b01001, m5(5'b00011,Z,Z,5'b11000,Z), ALL, m5(5'b00011,Z,Z,5'b11000,Z), 5'b11011));
        tbl.push_back(mk(5'b01001, 5'b01001, 5'b01001, m5(5'b00011,Z,Z,5'b11000,Z), ALL, '0, Z));
        tbl.push_back(mk(Z, Z, Z, '0, ALL, '0, Z));
        // Partial overlap: input 1 holds output 1, input 2 wants outputs 1,2.
        tbl.push_back(mk(5'b00010, 5'b00010, Z, m5(Z,5'b00010,Z,Z,Z), ALL, m5(Z,5'b00010,Z,Z,Z), 5'b00010));
        tbl.push_back(mk(5'b00110, 5'b00110, 5'b00100, m5(Z,5'b00010,5'b00110,Z,Z), ALL, m5(Z,5'b00010,Z,Z,Z), 5'b00010));
        tbl.push_back(mk(5'b00110, 5'b00100, 5'b00110, m5(Z,5'b00010,5'b00110,Z,Z), ALL, '0, Z));
        tbl.push_back(mk(5'b00100, 5'b00100, 5'b00100, m5(Z,Z,5'b00110,Z,Z), ALL, m5(Z,Z,5'b00110,Z,Z), 5'b00110));
        tbl.push_back(mk(5'b00100, 5'b00100, 5'b00100, m5(Z,Z,5'b00110,Z,Z), ALL, '0, Z));
        // Zero-route head and orphan body flit are never granted.
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00001, '0, ALL, '0, Z));
        tbl.push_back(mk(5'b00001, Z, Z, m5(5'b00001,Z,Z,Z,Z), ALL, '0, Z));

        drive(Z, Z, Z, '0, ALL);
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel", {7'd0, sel_all}, 32'd0);
        check("reset_busy", {27'd0, busy_out}, 32'd0);
        rstn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].v, tbl[k].h, tbl[k].t, tbl[k].r, tbl[k].rdy);
            tick();
            check($sformatf("vec%0d_sel", k), {7'd0, sel_all}, {7'd0, tbl[k].sel});
            check($sformatf("vec%0d_busy", k), {27'd0, busy_out}, {27'd0, tbl[k].busy});
        end

        // Asynchronous reset in the middle of a packet.
        drive(5'b00010, 5'b00010, Z, m5(Z,5'b00100,Z,Z,Z), ALL);
        tick();
        check("pre_reset_sel1", {27'd0, sel1}, 32'd4);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_sel", {7'd0, sel_all}, 32'd0);
        check("async_reset_busy", {27'd0, busy_out}, 32'd0);
        drive(Z, Z, Z, '0, ALL);
        tick();
        rstn = 1'b1;

        // Inputs 2 and 4 contend for output 0 from pointer RR_INIT = 0.
        for (int pkt = 0; pkt < 4; pkt++) begin
            logic [4:0] exp2, exp4;
            exp2 = (pkt % 2 == 0) ? 5'b00001 : 5'b00000;
            exp4 = (pkt % 2 == 0) ? 5'b00000 : 5'b00001;
            drive(5'b10100, 5'b10100, 5'b10100, m5(Z,Z,5'b00001,Z,5'b00001), ALL);
            tick();
            check($sformatf("rr_pkt%0d_grant", pkt), {22'd0, sel4, sel2}, {22'd0, exp4, exp2});
            tick();
            check($sformatf("rr_pkt%0d_release", pkt), {22'd0, sel4, sel2}, 32'd0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_p = 0;
        for (int i = 0; i < 5; i++) m_own[i] = '0;
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] v, h, t, rdy;
            logic [24:0] r;
            v = 5'($urandom) | 5'($urandom);
            h = 5'($urandom);
            t = 5'($urandom) & 5'($urandom | 32'h15);
            r = 25'($urandom);
            rdy = 5'($urandom) | 5'($urandom) | 5'($urandom);
            drive(v, h, t, r, rdy);
            model_step();
            tick();
            for (int i = 0; i < 5; i++) m_own[i] = m_nxt[i];
            begin
                logic [4:0] mb;
                mb = '0;
                for (int i = 0; i < 5; i++) mb |= m_own[i];
                check($sformatf("rand%0d", c), {2'd0, busy_out, sel_all},
                      {2'd0, mb, m_own[4], m_own[3], m_own[2], m_own[1], m_own[0]});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
